// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//  Shared definitions for the IFU/LSU memory-port arbiter: FSM state
//  encoding, master identifiers for the round-robin pointer, AXI response
//  codes and the IDLE-state arbitration function.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Raw state encodings, kept as plain constants so other blocks and
    // debug logic can decode the arbiter state without the enum type.
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_RD_IFU = 2'd1;
    localparam logic [1:0] ARB_RD_LSU = 2'd2;
    localparam logic [1:0] ARB_WR_LSU = 2'd3;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Identity of the last granted master.
    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = ARB_IDLE,
        ST_RD_IFU = ARB_RD_IFU,
        ST_RD_LSU = ARB_RD_LSU,
        ST_WR_LSU = ARB_WR_LSU
    } arb_state_t;

    // Next state out of IDLE. On a tie the master that was not granted
    // last wins. Once the LSU is chosen, a complete write request (AW and
    // W both valid) takes priority over its read request.
    function automatic arb_state_t arb_pick(input logic ifu_req,
                                            input logic lsu_req,
                                            input logic lsu_wr,
                                            input logic rr_last);
        arb_state_t nxt;
        nxt = ST_IDLE;
        if (ifu_req && (!lsu_req || rr_last == MST_LSU)) begin
            nxt = ST_RD_IFU;
        end else if (lsu_req) begin
            nxt = lsu_wr ? ST_WR_LSU : ST_RD_LSU;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//  Bundle of every handshake/bus signal around the arbiter: the IFU port
//  (read only), the LSU port (read + write) and the MMU-side port (m_*).
//  Each request carries the requester's satp so the MMU translates in the
//  right context.
//  Modports:
//   slave  - the arbiter's view: it serves IFU/LSU and drives the MMU side.
//   master - the surrounding system's view: IFU, LSU and the MMU.
//  Parameters: ADDR_W (address and satp width), DATA_W (data width,
//  strobe width is DATA_W/8).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // IFU read port
    logic [ADDR_W-1:0] ifu_araddr;
    logic [2:0]        ifu_arsize;
    logic [7:0]        ifu_arlen;
    logic [1:0]        ifu_arburst;
    logic [ADDR_W-1:0] ifu_arsatp;
    logic              ifu_arvalid;
    logic              ifu_arready;
    logic [DATA_W-1:0] ifu_rdata;
    logic [1:0]        ifu_rresp;
    logic              ifu_rlast;
    logic              ifu_rvalid;
    logic              ifu_rready;

    // LSU read port
    logic [ADDR_W-1:0] lsu_araddr;
    logic [2:0]        lsu_arsize;
    logic [7:0]        lsu_arlen;
    logic [1:0]        lsu_arburst;
    logic [ADDR_W-1:0] lsu_arsatp;
    logic              lsu_arvalid;
    logic              lsu_arready;
    logic [DATA_W-1:0] lsu_rdata;
    logic [1:0]        lsu_rresp;
    logic              lsu_rlast;
    logic              lsu_rvalid;
    logic              lsu_rready;

    // LSU write port
    logic [ADDR_W-1:0] lsu_awaddr;
    logic [ADDR_W-1:0] lsu_awsatp;
    logic              lsu_awvalid;
    logic              lsu_awready;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              lsu_wvalid;
    logic              lsu_wready;
    logic [1:0]        lsu_bresp;
    logic              lsu_bvalid;
    logic              lsu_bready;

    // MMU-side port
    logic [ADDR_W-1:0] m_araddr;
    logic [2:0]        m_arsize;
    logic [7:0]        m_arlen;
    logic [1:0]        m_arburst;
    logic [ADDR_W-1:0] m_arsatp;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              m_rvalid;
    logic              m_rready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [ADDR_W-1:0] m_awsatp;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;

    modport slave (
        input  ifu_araddr, ifu_arsize, ifu_arlen, ifu_arburst, ifu_arsatp,
               ifu_arvalid, ifu_rready,
        output ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
        input  lsu_araddr, lsu_arsize, lsu_arlen, lsu_arburst, lsu_arsatp,
               lsu_arvalid, lsu_rready,
        output lsu_arready, lsu_rdata, lsu_rresp, lsu_rlast, lsu_rvalid,
        input  lsu_awaddr, lsu_awsatp, lsu_awvalid, lsu_wdata, lsu_wstrb,
               lsu_wvalid, lsu_bready,
        output lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        output m_araddr, m_arsize, m_arlen, m_arburst, m_arsatp, m_arvalid,
               m_rready,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_awaddr, m_awsatp, m_awvalid, m_wdata, m_wstrb, m_wvalid,
               m_bready,
        input  m_awready, m_wready, m_bresp, m_bvalid
    );

    modport master (
        output ifu_araddr, ifu_arsize, ifu_arlen, ifu_arburst, ifu_arsatp,
               ifu_arvalid, ifu_rready,
        input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
        output lsu_araddr, lsu_arsize, lsu_arlen, lsu_arburst, lsu_arsatp,
               lsu_arvalid, lsu_rready,
        input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rlast, lsu_rvalid,
        output lsu_awaddr, lsu_awsatp, lsu_awvalid, lsu_wdata, lsu_wstrb,
               lsu_wvalid, lsu_bready,
        input  lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
        input  m_araddr, m_arsize, m_arlen, m_arburst, m_arsatp, m_arvalid,
               m_rready,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_awaddr, m_awsatp, m_awvalid, m_wdata, m_wstrb, m_wvalid,
               m_bready,
        output m_awready, m_wready, m_bresp, m_bvalid
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//  Shares the MMU's single upstream port between the IFU (reads only) and
//  the LSU (reads and writes). A grant covers one whole transaction: AR
//  through the last R beat, or AW+W through B. Arbitration happens only in
//  IDLE and is registered, so each grant costs one idle bubble cycle and
//  there is no combinational path from the request valids to the grant.
//  Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave: IFU, LSU and MMU-side channels
//  Address/data widths come from the interface parameters ADDR_W/DATA_W.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mem_port_arbiter_if.slave      bus
);

    arb_state_t state;
    logic       rr_last;

    logic ifu_req;
    logic lsu_req;
    logic lsu_wr;
    logic rd_ifu;
    logic rd_lsu;
    logic wr_lsu;

    assign ifu_req = bus.ifu_arvalid;
    assign lsu_wr  = bus.lsu_awvalid & bus.lsu_wvalid;
    assign lsu_req = lsu_wr | bus.lsu_arvalid;

    assign rd_ifu = (state == ST_RD_IFU);
    assign rd_lsu = (state == ST_RD_LSU);
    assign wr_lsu = (state == ST_WR_LSU);

    // Grant FSM. The grant is locked until the owning transaction's final
    // handshake (last R beat or B), even if the owner drops its valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_last <= MST_LSU;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= arb_pick(ifu_req, lsu_req, lsu_wr, rr_last);
                    if (ifu_req && (!lsu_req || rr_last == MST_LSU)) begin
                        rr_last <= MST_IFU;
                    end else if (lsu_req) begin
                        rr_last <= MST_LSU;
                    end
                end
                ST_RD_IFU: begin
                    if (bus.m_rvalid && bus.ifu_rready && bus.m_rlast) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_LSU: begin
                    if (bus.m_rvalid && bus.lsu_rready && bus.m_rlast) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR_LSU: begin
                    if (bus.m_bvalid && bus.lsu_bready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read address mux. Payload follows the LSU only while it owns the
    // read path; every valid is qualified by the state.
    assign bus.m_araddr  = rd_lsu ? bus.lsu_araddr  : bus.ifu_araddr;
    assign bus.m_arsize  = rd_lsu ? bus.lsu_arsize  : bus.ifu_arsize;
    assign bus.m_arlen   = rd_lsu ? bus.lsu_arlen   : bus.ifu_arlen;
    assign bus.m_arburst = rd_lsu ? bus.lsu_arburst : bus.ifu_arburst;
    assign bus.m_arsatp  = rd_lsu ? bus.lsu_arsatp  : bus.ifu_arsatp;
    assign bus.m_arvalid = (rd_ifu & bus.ifu_arvalid) | (rd_lsu & bus.lsu_arvalid);
    assign bus.m_rready  = (rd_ifu & bus.ifu_rready)  | (rd_lsu & bus.lsu_rready);

    // arready is only ever the MMU's, steered to the owning master.
    assign bus.ifu_arready = rd_ifu & bus.m_arready;
    assign bus.lsu_arready = rd_lsu & bus.m_arready;

    // Read data fans out to both masters; only the owner sees rvalid.
    assign bus.ifu_rdata  = bus.m_rdata;
    assign bus.ifu_rresp  = bus.m_rresp;
    assign bus.ifu_rlast  = bus.m_rlast;
    assign bus.ifu_rvalid = rd_ifu & bus.m_rvalid;
    assign bus.lsu_rdata  = bus.m_rdata;
    assign bus.lsu_rresp  = bus.m_rresp;
    assign bus.lsu_rlast  = bus.m_rlast;
    assign bus.lsu_rvalid = rd_lsu & bus.m_rvalid;

    // Write path: only the LSU writes, so the payload is wired straight
    // through and just the handshakes are gated by the write grant.
    assign bus.m_awaddr    = bus.lsu_awaddr;
    assign bus.m_awsatp    = bus.lsu_awsatp;
    assign bus.m_awvalid   = wr_lsu & bus.lsu_awvalid;
    assign bus.lsu_awready = wr_lsu & bus.m_awready;
    assign bus.m_wdata     = bus.lsu_wdata;
    assign bus.m_wstrb     = bus.lsu_wstrb;
    assign bus.m_wvalid    = wr_lsu & bus.lsu_wvalid;
    assign bus.lsu_wready  = wr_lsu & bus.m_wready;
    assign bus.lsu_bresp   = bus.m_bresp;
    assign bus.lsu_bvalid  = wr_lsu & bus.m_bvalid;
    assign bus.m_bready    = wr_lsu & bus.lsu_bready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Directed bench for mem_port_arbiter. The bench plays IFU, LSU and MMU by
//  driving the interface directly; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every valid/ready the arbiter drives, packed for the all-quiet checks.
    function automatic logic [11:0] hs_outputs();
        return {bus.ifu_arready, bus.ifu_rvalid, bus.lsu_arready, bus.lsu_rvalid,
                bus.lsu_awready, bus.lsu_wready, bus.lsu_bvalid, bus.m_arvalid,
                bus.m_rready, bus.m_awvalid, bus.m_wvalid, bus.m_bready};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the current inputs for the given number of clock edges, then
    // leaves the bench 1 ns past the last edge so outputs are settled.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearInputs();
        bus.ifu_araddr  = '0; bus.ifu_arsize = 3'd2; bus.ifu_arlen = '0;
        bus.ifu_arburst = 2'd1; bus.ifu_arsatp = '0; bus.ifu_arvalid = 1'b0;
        bus.ifu_rready  = 1'b0;
        bus.lsu_araddr  = '0; bus.lsu_arsize = 3'd2; bus.lsu_arlen = '0;
        bus.lsu_arburst = 2'd1; bus.lsu_arsatp = '0; bus.lsu_arvalid = 1'b0;
        bus.lsu_rready  = 1'b0;
        bus.lsu_awaddr  = '0; bus.lsu_awsatp = '0; bus.lsu_awvalid = 1'b0;
        bus.lsu_wdata   = '0; bus.lsu_wstrb = '0; bus.lsu_wvalid = 1'b0;
        bus.lsu_bready  = 1'b0;
        bus.m_arready = 1'b0; bus.m_rdata = '0; bus.m_rresp = RESP_OKAY;
        bus.m_rlast   = 1'b0; bus.m_rvalid = 1'b0;
        bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_bresp   = RESP_OKAY; bus.m_bvalid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clearInputs();
        applyStimulus(2);

        // Reset state
        checkOutput("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("rst_rr_last", 64'(dut.rr_last), 64'd1);
        checkOutput("rst_handshakes", 64'(hs_outputs()), 64'd0);
        rst = 1'b0;

        // 1: IFU-only read
        $display("[TB] IFU-only read");
        bus.ifu_araddr  = 32'h8000_0000;
        bus.ifu_arsatp  = 32'h8000_1234;
        bus.ifu_arlen   = 8'd0;
        bus.ifu_arvalid = 1'b1;
        #1;
        checkOutput("t1_idle_no_fwd", 64'(bus.m_arvalid), 64'd0);
        applyStimulus(1);
        checkOutput("t1_state_rd_ifu", 64'(dut.state), 64'(ARB_RD_IFU));
        checkOutput("t1_m_arvalid", 64'(bus.m_arvalid), 64'd1);
        checkOutput("t1_m_araddr", 64'(bus.m_araddr), 64'h8000_0000);
        checkOutput("t1_m_arsatp", 64'(bus.m_arsatp), 64'h8000_1234);
        checkOutput("t1_arready_wait", 64'(bus.ifu_arready), 64'd0);
        bus.m_arready = 1'b1;
        #1;
        checkOutput("t1_arready_pass", 64'(bus.ifu_arready), 64'd1);
        applyStimulus(1);
        bus.ifu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rdata     = 32'hDEAD_BEEF;
        bus.m_rlast     = 1'b1;
        bus.m_rvalid    = 1'b1;
        bus.ifu_rready  = 1'b1;
        #1;
        checkOutput("t1_ifu_rvalid", 64'(bus.ifu_rvalid), 64'd1);
        checkOutput("t1_ifu_rdata", 64'(bus.ifu_rdata), 64'hDEAD_BEEF);
        checkOutput("t1_ifu_rlast", 64'(bus.ifu_rlast), 64'd1);
        checkOutput("t1_lsu_rvalid", 64'(bus.lsu_rvalid), 64'd0);
        checkOutput("t1_m_rready", 64'(bus.m_rready), 64'd1);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("t1_back_idle", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("t1_idle_quiet", 64'(hs_outputs()), 64'd0);

        // 2: simultaneous IFU and LSU reads straight after reset
        $display("[TB] IFU/LSU read tie");
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        bus.ifu_araddr  = 32'h0000_1000;
        bus.ifu_arvalid = 1'b1;
        bus.lsu_araddr  = 32'h0000_2000;
        bus.lsu_arsatp  = 32'h0000_AAAA;
        bus.lsu_arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t2_first_ifu", 64'(dut.state), 64'(ARB_RD_IFU));
        checkOutput("t2_rr_ifu", 64'(dut.rr_last), 64'd0);
        bus.m_arready = 1'b1;
        #1;
        checkOutput("t2_ifu_arready", 64'(bus.ifu_arready), 64'd1);
        checkOutput("t2_lsu_arready_blk", 64'(bus.lsu_arready), 64'd0);
        checkOutput("t2_m_araddr_ifu", 64'(bus.m_araddr), 64'h0000_1000);
        applyStimulus(1);
        bus.ifu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rdata     = 32'h1111_1111;
        bus.m_rlast     = 1'b1;
        bus.m_rvalid    = 1'b1;
        bus.ifu_rready  = 1'b1;
        applyStimulus(1);
        bus.m_rvalid    = 1'b0;
        bus.ifu_rready  = 1'b0;
        bus.ifu_arvalid = 1'b1;
        #1;
        checkOutput("t2_idle_bubble", 64'(dut.state), 64'(ARB_IDLE));
        applyStimulus(1);
        checkOutput("t2_second_lsu", 64'(dut.state), 64'(ARB_RD_LSU));
        checkOutput("t2_rr_lsu", 64'(dut.rr_last), 64'd1);
        checkOutput("t2_m_araddr_lsu", 64'(bus.m_araddr), 64'h0000_2000);
        checkOutput("t2_m_arsatp_lsu", 64'(bus.m_arsatp), 64'h0000_AAAA);
        bus.m_arready = 1'b1;
        #1;
        checkOutput("t2_lsu_arready", 64'(bus.lsu_arready), 64'd1);
        checkOutput("t2_ifu_arready_blk", 64'(bus.ifu_arready), 64'd0);
        applyStimulus(1);
        bus.lsu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rdata     = 32'h2222_2222;
        bus.m_rvalid    = 1'b1;
        bus.lsu_rready  = 1'b1;
        #1;
        checkOutput("t2_lsu_rdata", 64'(bus.lsu_rdata), 64'h2222_2222);
        checkOutput("t2_ifu_rvalid_blk", 64'(bus.ifu_rvalid), 64'd0);
        applyStimulus(1);
        bus.m_rvalid    = 1'b0;
        bus.lsu_rready  = 1'b0;
        bus.lsu_arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t2_third_ifu", 64'(dut.state), 64'(ARB_RD_IFU));
        bus.m_arready = 1'b1;
        applyStimulus(1);
        bus.ifu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rvalid    = 1'b1;
        bus.ifu_rready  = 1'b1;
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("t2_end_idle", 64'(dut.state), 64'(ARB_IDLE));

        // 3: LSU write and read requested together, write wins
        $display("[TB] LSU write over read");
        bus.lsu_awaddr  = 32'h4000_0010;
        bus.lsu_awsatp  = 32'h8000_5678;
        bus.lsu_awvalid = 1'b1;
        bus.lsu_wdata   = 32'hCAFE_F00D;
        bus.lsu_wstrb   = 4'b0110;
        bus.lsu_wvalid  = 1'b1;
        bus.lsu_araddr  = 32'h0000_3000;
        bus.lsu_arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t3_state_wr", 64'(dut.state), 64'(ARB_WR_LSU));
        checkOutput("t3_m_awvalid", 64'(bus.m_awvalid), 64'd1);
        checkOutput("t3_m_wvalid", 64'(bus.m_wvalid), 64'd1);
        checkOutput("t3_m_arvalid", 64'(bus.m_arvalid), 64'd0);
        checkOutput("t3_m_awaddr", 64'(bus.m_awaddr), 64'h4000_0010);
        checkOutput("t3_m_awsatp", 64'(bus.m_awsatp), 64'h8000_5678);
        checkOutput("t3_m_wdata", 64'(bus.m_wdata), 64'hCAFE_F00D);
        checkOutput("t3_m_wstrb", 64'(bus.m_wstrb), 64'h6);
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        #1;
        checkOutput("t3_aw_w_ready", 64'({bus.lsu_awready, bus.lsu_wready}), 64'h3);
        checkOutput("t3_lsu_arready_blk", 64'(bus.lsu_arready), 64'd0);
        applyStimulus(1);
        bus.lsu_awvalid = 1'b0;
        bus.lsu_wvalid  = 1'b0;
        bus.m_awready   = 1'b0;
        bus.m_wready    = 1'b0;
        bus.m_bresp     = RESP_SLVERR;
        bus.m_bvalid    = 1'b1;
        bus.lsu_bready  = 1'b1;
        #1;
        checkOutput("t3_lsu_bvalid", 64'(bus.lsu_bvalid), 64'd1);
        checkOutput("t3_lsu_bresp", 64'(bus.lsu_bresp), 64'(RESP_SLVERR));
        checkOutput("t3_m_bready", 64'(bus.m_bready), 64'd1);
        applyStimulus(1);
        clearInputs();
        #1;
        checkOutput("t3_end_idle", 64'(dut.state), 64'(ARB_IDLE));

        // 6: B held off by the LSU, pending IFU read must wait
        $display("[TB] B backpressure");
        bus.lsu_awvalid = 1'b1;
        bus.lsu_wvalid  = 1'b1;
        applyStimulus(1);
        checkOutput("t6_state_wr", 64'(dut.state), 64'(ARB_WR_LSU));
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        applyStimulus(1);
        bus.lsu_awvalid = 1'b0;
        bus.lsu_wvalid  = 1'b0;
        bus.m_awready   = 1'b0;
        bus.m_wready    = 1'b0;
        bus.m_bvalid    = 1'b1;
        bus.lsu_bready  = 1'b0;
        bus.ifu_arvalid = 1'b1;
        bus.m_arready   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("t6_hold_state", 64'(dut.state), 64'(ARB_WR_LSU));
            checkOutput("t6_no_ar_fwd", 64'(bus.m_arvalid), 64'd0);
            checkOutput("t6_ifu_arready", 64'(bus.ifu_arready), 64'd0);
        end
        bus.lsu_bready = 1'b1;
        applyStimulus(1);
        bus.m_bvalid   = 1'b0;
        bus.lsu_bready = 1'b0;
        #1;
        checkOutput("t6_exit_idle", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("t6_idle_no_ar", 64'(bus.m_arvalid), 64'd0);
        applyStimulus(1);
        checkOutput("t6_ifu_granted", 64'(dut.state), 64'(ARB_RD_IFU));
        checkOutput("t6_ifu_arready", 64'(bus.ifu_arready), 64'd1);
        applyStimulus(1);
        bus.ifu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rlast     = 1'b1;
        bus.m_rvalid    = 1'b1;
        bus.ifu_rready  = 1'b1;
        applyStimulus(1);
        clearInputs();

        // 4: LSU read with stalled R, IFU arrives mid-transaction
        $display("[TB] LSU read, IFU waits");
        bus.lsu_araddr  = 32'h0000_5000;
        bus.lsu_arlen   = 8'd1;
        bus.lsu_arvalid = 1'b1;
        applyStimulus(1);
        checkOutput("t4_state_rd_lsu", 64'(dut.state), 64'(ARB_RD_LSU));
        bus.m_arready   = 1'b1;
        bus.ifu_arvalid = 1'b1;
        applyStimulus(1);
        bus.lsu_arvalid = 1'b0;
        bus.lsu_rready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("t4_stall_ifu_arready", 64'(bus.ifu_arready), 64'd0);
            checkOutput("t4_stall_state", 64'(dut.state), 64'(ARB_RD_LSU));
        end
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b0;
        applyStimulus(1);
        checkOutput("t4_nonlast_beat", 64'(dut.state), 64'(ARB_RD_LSU));
        bus.m_rlast    = 1'b1;
        bus.lsu_rready = 1'b0;
        applyStimulus(1);
        checkOutput("t4_last_not_ready", 64'(dut.state), 64'(ARB_RD_LSU));
        bus.lsu_rready = 1'b1;
        applyStimulus(1);
        bus.m_rvalid   = 1'b0;
        bus.lsu_rready = 1'b0;
        #1;
        checkOutput("t4_exit_idle", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("t4_idle_ifu_arready", 64'(bus.ifu_arready), 64'd0);
        applyStimulus(1);
        checkOutput("t4_ifu_after", 64'(dut.state), 64'(ARB_RD_IFU));
        checkOutput("t4_ifu_arready", 64'(bus.ifu_arready), 64'd1);
        checkOutput("t4_rr_ifu", 64'(dut.rr_last), 64'd0);
        applyStimulus(1);
        bus.ifu_arvalid = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rlast     = 1'b1;
        bus.m_rvalid    = 1'b1;
        bus.ifu_rready  = 1'b1;
        applyStimulus(1);
        clearInputs();

        // 5: reset while a B response is pending
        $display("[TB] reset mid-write");
        bus.lsu_awvalid = 1'b1;
        bus.lsu_wvalid  = 1'b1;
        applyStimulus(1);
        checkOutput("t5_state_wr", 64'(dut.state), 64'(ARB_WR_LSU));
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        applyStimulus(1);
        bus.lsu_awvalid = 1'b0;
        bus.lsu_wvalid  = 1'b0;
        bus.m_awready   = 1'b0;
        bus.m_wready    = 1'b0;
        bus.m_bvalid    = 1'b1;
        bus.lsu_bready  = 1'b1;
        bus.ifu_arvalid = 1'b1;
        bus.lsu_arvalid = 1'b1;
        bus.ifu_rready  = 1'b1;
        bus.m_rvalid    = 1'b1;
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("t5_rst_idle", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("t5_rst_quiet", 64'(hs_outputs()), 64'd0);
        checkOutput("t5_rst_rr_last", 64'(dut.rr_last), 64'd1);
        bus.m_bvalid   = 1'b0;
        bus.m_rvalid   = 1'b0;
        bus.lsu_bready = 1'b0;
        bus.ifu_rready = 1'b0;
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("t5_tie_ifu", 64'(dut.state), 64'(ARB_RD_IFU));
        checkOutput("t5_rr_ifu", 64'(dut.rr_last), 64'd0);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("t5_rst_rd_idle", 64'(dut.state), 64'(ARB_IDLE));
        checkOutput("t5_rst_rr_back", 64'(dut.rr_last), 64'd1);
        rst = 1'b0;
        clearInputs();
        applyStimulus(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
